uart_loop_ctrl: RTL and testbench

Parametrised UART loop-back controller that sits between the uart core's FIFO interface (rd_uart/wr_uart/r_data/w_data/rx_empty/tx_full) and board I/O. It pops received bytes, applies a selectable transform, and writes them back to the transmitter, either one byte per debounced button tick or continuously. It handles transmitter back-pressure with an optional drop timeout and keeps saturating byte/drop counters and the last received byte for LED/seven-segment status display.

---
 rtl/uart_loop_ctrl_if.sv | 21 ++
 rtl/uart_loop_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_loop_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loop_ctrl_if.sv
// FIFO-side handshake between the loop-back controller (master) and the UART core (slave).
interface uart_loop_ctrl_if #(
  parameter int DBIT = 8
);
  logic            rd_uart;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            tx_full;

  modport master (
    output rd_uart, wr_uart, w_data,
    input  r_data, rx_empty, tx_full
  );

  modport slave (
    input  rd_uart, wr_uart, w_data,
    output r_data, rx_empty, tx_full
  );
endinterface

// File: rtl/uart_loop_ctrl.sv
// UART loop-back controller: pops rx bytes, transforms them and pushes them to tx,
// per step tick or continuously, with optional drop on prolonged tx back-pressure.
module uart_loop_ctrl #(
  parameter int DBIT    = 8,
  parameter int OFFSET  = 1,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             auto,
  input  logic [1:0]       xsel,
  input  logic             step,
  uart_loop_ctrl_if.master fifo,
  output logic [DBIT-1:0]  last_rx,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             pending,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  localparam bit              HAS_TO  = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HAS_TO ? TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [DBIT-1:0]  r_last;
  logic [DBIT-1:0]  r_wdata;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [TO_W-1:0]  r_to;
  logic             r_pending;
  logic             w_trigger;
  logic             w_enter;
  logic             w_drop;
  logic             w_rd;
  logic             w_wr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DBIT-1:0] xform(input logic [DBIT-1:0] d, input logic [1:0] sel);
    logic [DBIT-1:0] rev;
    for (int i = 0; i < DBIT; i++) rev[i] = d[DBIT-1-i];
    case (sel)
      2'b00:   return d;
      2'b01:   return d + DBIT'(OFFSET);
      2'b10:   return ~d;
      default: return rev;
    endcase
  endfunction

  assign w_trigger = auto | r_pending;

  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    w_drop  = 1'b0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger && !fifo.rx_empty) begin
          w_next  = FETCH;
          w_enter = 1'b1;
        end
      end
      FETCH: begin
        w_rd   = 1'b1;
        w_next = SEND;
      end
      SEND: begin
        if (!fifo.tx_full) begin
          w_wr   = 1'b1;
          w_next = IDLE;
        end else if (HAS_TO && r_to == TO_LAST) begin
          w_drop = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last     <= '0;
      r_wdata    <= '0;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_to       <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state <= w_next;
      // A step coinciding with FETCH entry re-arms the request instead of being lost.
      if (w_enter)   r_pending <= step;
      else if (step) r_pending <= 1'b1;
      case (r_state)
        FETCH: begin
          r_last   <= fifo.r_data;
          r_wdata  <= xform(fifo.r_data, xsel);
          r_rx_cnt <= sat_inc(r_rx_cnt);
          r_to     <= '0;
        end
        SEND: begin
          if (w_wr) begin
            r_tx_cnt <= sat_inc(r_tx_cnt);
            r_to     <= '0;
          end else if (w_drop) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
            r_to       <= '0;
          end else if (r_to != '1) begin
            r_to <= r_to + 1'b1;
          end
        end
        default: r_to <= '0;
      endcase
    end
  end

  assign fifo.rd_uart = w_rd;
  assign fifo.wr_uart = w_wr;
  assign fifo.w_data  = r_wdata;
  assign last_rx      = r_last;
  assign rx_count     = r_rx_cnt;
  assign tx_count     = r_tx_cnt;
  assign drop_count   = r_drop_cnt;
  assign pending      = r_pending;
  assign busy         = (r_state != IDLE);
endmodule

// File: tb/tb_uart_loop_ctrl.sv
// Bench for uart_loop_ctrl: directed steps plus randomized streams against a byte-level model.
module tb_uart_loop_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       auto = 1'b0;
  logic       step = 1'b0;
  logic [1:0] xsel = 2'b00;

  always #5 clk = ~clk;

  uart_loop_ctrl_if #(.DBIT(8)) ifa ();
  uart_loop_ctrl_if #(.DBIT(8)) ifb ();

  logic [7:0]  a_last, b_last;
  logic [3:0]  a_rx, a_tx, a_drop;
  logic [15:0] b_rx, b_tx, b_drop;
  logic        a_pend, a_busy, b_pend, b_busy;

  uart_loop_ctrl #(.DBIT(8), .OFFSET(1), .CNT_W(4), .TIMEOUT(8), .TO_W(16)) dut_a (
    .clk(clk), .reset(reset), .auto(auto), .xsel(xsel), .step(step), .fifo(ifa),
    .last_rx(a_last), .rx_count(a_rx), .tx_count(a_tx), .drop_count(a_drop),
    .pending(a_pend), .busy(a_busy)
  );

  uart_loop_ctrl #(.DBIT(8), .OFFSET(1), .CNT_W(16), .TIMEOUT(0), .TO_W(16)) dut_b (
    .clk(clk), .reset(reset), .auto(auto), .xsel(xsel), .step(step), .fifo(ifb),
    .last_rx(b_last), .rx_count(b_rx), .tx_count(b_tx), .drop_count(b_drop),
    .pending(b_pend), .busy(b_busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int         rd_cyc[$];
  int         m_rx = 0, m_tx = 0, m_drop = 0;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xref(input logic [7:0] b, input logic [1:0] s);
    int v, r;
    v = int'(b);
    r = 0;
    case (s)
      2'b00: return b;
      2'b01: return 8'((v + 1) % 256);
      2'b10: return 8'(255 - v);
      default: begin
        for (int i = 0; i < 8; i++) r = r * 2 + ((v >> i) & 1);
        return 8'(r);
      end
    endcase
  endfunction

  function automatic logic [31:0] sat4(input int m);
    return 32'((m > 15) ? 15 : m);
  endfunction

  task automatic fifo_drive();
    ifa.rx_empty = (rxq.size() == 0);
    ifa.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic cyc();
    logic rd, wr;
    logic [7:0] e;
    rd = ifa.rd_uart;
    wr = ifa.wr_uart;
    if (rd === 1'b1) begin
      m_rx++;
      m_last = ifa.r_data;
      expq.push_back(xref(ifa.r_data, xsel));
      rd_cyc.push_back(cycle);
    end
    if (wr === 1'b1) begin
      e = 8'hxx;
      if (expq.size() != 0) e = expq.pop_front();
      chk("w_data_stream", 32'(ifa.w_data), 32'(e));
      m_tx++;
    end
    @(posedge clk);
    #1;
    cycle++;
    if (rd === 1'b1 && rxq.size() != 0) void'(rxq.pop_front());
    fifo_drive();
    #1;
  endtask

  task automatic clear_model();
    m_rx = 0; m_tx = 0; m_drop = 0; m_last = 8'h00;
    expq.delete();
    rd_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    clear_model();
    reset = 1'b1;
    #1;
  endtask

  task automatic run_xf(input string tag, input logic [7:0] b, input logic [1:0] s,
                        input logic [7:0] exp);
    xsel = s;
    rxq.push_back(b);
    fifo_drive();
    #1;
    repeat (4) cyc();
    chk(tag, 32'(ifa.w_data), 32'(exp));
    chk({tag, "_last"}, 32'(a_last), 32'(b));
  endtask

  initial begin
    int n, wrs, bad, run, guard;
    logic tx;
    ifa.tx_full  = 1'b0;
    ifb.tx_full  = 1'b0;
    ifb.rx_empty = 1'b1;
    ifb.r_data   = 8'h00;

    // Reset held with data available and auto on
    rxq.push_back(8'h5A);
    fifo_drive();
    auto = 1'b1;
    reset = 1'b0;
    cyc();
    cyc();
    chk("rst_rd", 32'(ifa.rd_uart), 0);
    chk("rst_wr", 32'(ifa.wr_uart), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_pend", 32'(a_pend), 0);
    chk("rst_rx", 32'(a_rx), 0);
    chk("rst_tx", 32'(a_tx), 0);
    chk("rst_drop", 32'(a_drop), 0);
    chk("rst_last", 32'(a_last), 0);
    chk("rst_wdata", 32'(ifa.w_data), 0);
    clear_model();
    reset = 1'b1;
    #1;
    chk("rel_rd0", 32'(ifa.rd_uart), 0);
    cyc();
    chk("rel_rd1", 32'(ifa.rd_uart), 1);
    cyc();
    chk("rel_wr", 32'(ifa.wr_uart), 1);
    cyc();
    chk("rel_busy", 32'(a_busy), 0);
    chk("rel_rx", 32'(a_rx), sat4(m_rx));
    chk("rel_tx", 32'(a_tx), sat4(m_tx));
    chk("rel_last", 32'(a_last), 32'(m_last));

    // Manual step with +1 transform; a second step while pending is not queued
    do_reset();
    auto = 1'b0;
    xsel = 2'b01;
    step = 1'b1; cyc(); step = 1'b0;
    chk("man_pend", 32'(a_pend), 1);
    chk("man_idle", 32'(a_busy), 0);
    step = 1'b1; cyc(); step = 1'b0;
    chk("man_pend_hold", 32'(a_pend), 1);
    rxq.push_back(8'h41);
    rxq.push_back(8'h77);
    rxq.push_back(8'h10);
    fifo_drive();
    #1;
    cyc();
    chk("man_rd", 32'(ifa.rd_uart), 1);
    chk("man_pend_clr", 32'(a_pend), 0);
    cyc();
    chk("man_wr", 32'(ifa.wr_uart), 1);
    chk("man_wdata", 32'(ifa.w_data), 32'h42);
    chk("man_last", 32'(a_last), 32'h41);
    cyc();
    chk("man_rx", 32'(a_rx), 1);
    chk("man_tx", 32'(a_tx), 1);
    repeat (3) cyc();
    chk("man_one_byte", 32'(a_rx), 1);
    chk("man_idle2", 32'(a_busy), 0);
    // Step held across FETCH entry re-arms pending
    step = 1'b1; cyc(); cyc(); step = 1'b0;
    chk("man_coinc_rd", 32'(ifa.rd_uart), 1);
    chk("man_coinc_pend", 32'(a_pend), 1);
    cyc();
    cyc();
    cyc();
    chk("man_rearm_rd", 32'(ifa.rd_uart), 1);
    chk("man_rearm_pend", 32'(a_pend), 0);
    cyc();
    cyc();
    chk("man_rx3", 32'(a_rx), sat4(m_rx));
    chk("man_tx3", 32'(a_tx), sat4(m_tx));
    chk("man_last3", 32'(a_last), 32'h10);

    // Transforms and wrap
    auto = 1'b1;
    run_xf("xf_wrap", 8'hFF, 2'b01, 8'h00);
    run_xf("xf_inv", 8'h0F, 2'b10, 8'hF0);
    run_xf("xf_rev", 8'h01, 2'b11, 8'h80);
    run_xf("xf_pass", 8'hA5, 2'b00, 8'hA5);
    chk("xf_rx", 32'(a_rx), sat4(m_rx));

    // Back-pressure without timeout on the second instance
    xsel = 2'b00;
    ifb.r_data   = 8'h3C;
    ifb.tx_full  = 1'b1;
    ifb.rx_empty = 1'b0;
    #1;
    cyc();
    chk("bp_rd", 32'(ifb.rd_uart), 1);
    ifb.rx_empty = 1'b1;
    cyc();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (b_busy !== 1'b1 || ifb.wr_uart !== 1'b0) bad++;
      cyc();
    end
    chk("bp_hold", 32'(bad), 0);
    chk("bp_busy", 32'(b_busy), 1);
    ifb.tx_full = 1'b0;
    #1;
    chk("bp_wr", 32'(ifb.wr_uart), 1);
    chk("bp_wdata", 32'(ifb.w_data), 32'h3C);
    cyc();
    chk("bp_idle", 32'(b_busy), 0);
    chk("bp_tx", 32'(b_tx), 1);
    chk("bp_drop", 32'(b_drop), 0);

    // Drop after TIMEOUT cycles of tx_full
    ifa.tx_full = 1'b1;
    rxq.push_back(8'h99);
    fifo_drive();
    #1;
    cyc();
    chk("to_rd", 32'(ifa.rd_uart), 1);
    cyc();
    n = 0;
    wrs = 0;
    while (a_busy === 1'b1 && n < 20) begin
      if (ifa.wr_uart === 1'b1) wrs++;
      n++;
      cyc();
    end
    m_drop++;
    if (expq.size() != 0) void'(expq.pop_front());
    chk("to_cycles", 32'(n), 8);
    chk("to_no_wr", 32'(wrs), 0);
    chk("to_drop", 32'(a_drop), sat4(m_drop));
    chk("to_tx", 32'(a_tx), sat4(m_tx));
    ifa.tx_full = 1'b0;

    // Auto stream of 20 random bytes: 3-cycle cadence and counter saturation
    do_reset();
    xsel = 2'($urandom_range(0, 3));
    for (int i = 0; i < 20; i++) rxq.push_back(8'($urandom));
    fifo_drive();
    #1;
    repeat (70) cyc();
    chk("st_count", 32'(rd_cyc.size()), 20);
    bad = 0;
    for (int i = 1; i < rd_cyc.size(); i++) if (rd_cyc[i] - rd_cyc[i-1] != 3) bad++;
    chk("st_cadence", 32'(bad), 0);
    chk("st_rx_sat", 32'(a_rx), 15);
    chk("st_tx_sat", 32'(a_tx), sat4(m_tx));
    chk("st_last", 32'(a_last), 32'(m_last));

    // Reset mid-SEND abandons the byte
    ifa.tx_full = 1'b1;
    rxq.push_back(8'hC3);
    rxq.push_back(8'h3E);
    fifo_drive();
    #1;
    cyc();
    cyc();
    chk("ms_in_send", 32'({a_busy, ifa.rd_uart}), 32'b10);
    reset = 1'b0;
    cyc();
    chk("ms_rx", 32'(a_rx), 0);
    chk("ms_tx", 32'(a_tx), 0);
    chk("ms_drop", 32'(a_drop), 0);
    chk("ms_busy", 32'(a_busy), 0);
    chk("ms_last", 32'(a_last), 0);
    clear_model();
    reset = 1'b1;
    ifa.tx_full = 1'b0;

    // Random xsel and short tx_full bursts over a fresh stream
    for (int i = 0; i < 12; i++) rxq.push_back(8'($urandom));
    fifo_drive();
    #1;
    run = 0;
    guard = 0;
    while ((rxq.size() != 0 || a_busy === 1'b1) && guard < 400) begin
      xsel = 2'($urandom_range(0, 3));
      tx = (run >= 4) ? 1'b0 : ($urandom_range(0, 3) == 0);
      run = tx ? run + 1 : 0;
      ifa.tx_full = tx;
      #1;
      cyc();
      guard++;
    end
    ifa.tx_full = 1'b0;
    repeat (3) cyc();
    chk("rnd_drained", 32'(rxq.size()), 0);
    chk("rnd_expq", 32'(expq.size()), 0);
    chk("rnd_rx", 32'(a_rx), sat4(m_rx));
    chk("rnd_tx", 32'(a_tx), sat4(m_tx));
    chk("rnd_drop", 32'(a_drop), 0);
    chk("rnd_last", 32'(a_last), 32'(m_last));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
